// File: rtl/dsm_iq_correlator_pkg.sv
// Shared types and constants for the delta-sigma I/Q correlator and the SPI
// register block that feeds it weight vectors.
package dsm_iq_correlator_pkg;

    localparam int W_W   = 5;
    localparam int TAPS  = 8;
    localparam int DOT_W = 9;

    // Base byte addresses of the four weight banks in the SPI register map
    localparam logic [7:0] ADDR_W_COS_1 = 8'h10;
    localparam logic [7:0] ADDR_W_SIN_1 = 8'h18;
    localparam logic [7:0] ADDR_W_COS_2 = 8'h20;
    localparam logic [7:0] ADDR_W_SIN_2 = 8'h28;

    typedef logic signed [W_W-1:0]   lane_t;
    typedef lane_t [TAPS-1:0]        weight_vec_t;
    typedef logic signed [DOT_W-1:0] dot_t;

    // A set history bit adds the weight, a clear bit subtracts it. The weight
    // is widened first so that negating -16 yields +16 instead of wrapping.
    function automatic dot_t tap_term(input logic h, input lane_t w);
        dot_t ext;
        ext = dot_t'(w);
        return h ? ext : -ext;
    endfunction

endpackage

// File: rtl/dsm_iq_correlator_dot8.sv
// Eight-tap signed dot product of one weight vector against the bitstream
// history: per-tap terms registered first, then the adder tree result.
module dsm_iq_correlator_dot8
    import dsm_iq_correlator_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [TAPS-1:0] hist_i,
    input  weight_vec_t     w_i,
    output dot_t            dot_o
);

    dot_t term_p1_q [TAPS];
    dot_t dot_p2_d;
    dot_t dot_p2_q;

    // E1: one signed term per tap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) term_p1_q[k] <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) term_p1_q[k] <= tap_term(hist_i[k], w_i[k]);
        end
    end

    // Adder tree over the registered terms; 9 bits cover -128..+128
    always_comb begin
        dot_p2_d = '0;
        for (int k = 0; k < TAPS; k++) dot_p2_d = dot_p2_d + term_p1_q[k];
    end

    // E2: registered dot product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dot_p2_q <= '0;
        else       dot_p2_q <= dot_p2_d;
    end

    assign dot_o = dot_p2_q;

endmodule

// File: rtl/dsm_iq_correlator.sv
// Correlates the 1-bit delta-sigma stream against four 8-tap weight sets and
// integrates each dot product over WIN_LEN accepted samples, reporting two
// saturated I/Q pairs with a one-cycle valid pulse per window.
module dsm_iq_correlator
    import dsm_iq_correlator_pkg::*;
#(
    parameter int WIN_LEN = 64,
    parameter int ACC_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    bit_in,
    input  logic [7:0][4:0]         w_cos_1,
    input  logic [7:0][4:0]         w_sin_1,
    input  logic [7:0][4:0]         w_cos_2,
    input  logic [7:0][4:0]         w_sin_2,
    output logic signed [ACC_W-1:0] i1,
    output logic signed [ACC_W-1:0] q1,
    output logic signed [ACC_W-1:0] i2,
    output logic signed [ACC_W-1:0] q2,
    output logic                    out_valid,
    output logic                    overflow
);

    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int SUM_W = ACC_W + 2;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_LO   = -SAT_HI - SUM_W'(1);

    logic [TAPS-1:0]         hist_q;
    logic [CNT_W-1:0]        win_cnt_q;
    weight_vec_t             w_in [4];
    weight_vec_t             shadow_q [4];
    logic                    vld_p0_q, last_p0_q;
    logic                    vld_p1_q, last_p1_q;
    logic                    vld_p2_q, last_p2_q;
    dot_t                    dot_p2 [4];
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic signed [SUM_W-1:0] sum_d [4];
    logic signed [ACC_W-1:0] res_q [4];
    logic                    new_sat_d;
    logic                    sticky_q;
    logic                    out_valid_q;
    logic                    overflow_q;
    logic                    is_first;
    logic                    is_last;

    function automatic logic signed [ACC_W-1:0] sat_val(input logic signed [SUM_W-1:0] s);
        if (s > SAT_HI)      return SAT_HI[ACC_W-1:0];
        else if (s < SAT_LO) return SAT_LO[ACC_W-1:0];
        else                 return s[ACC_W-1:0];
    endfunction

    function automatic logic sat_hit(input logic signed [SUM_W-1:0] s);
        return (s > SAT_HI) || (s < SAT_LO);
    endfunction

    assign is_first = (win_cnt_q == '0);
    assign is_last  = (win_cnt_q == CNT_LAST);

    // Gather the four live weight buses in channel order cos1, sin1, cos2, sin2
    always_comb begin
        w_in[0] = w_cos_1;
        w_in[1] = w_sin_1;
        w_in[2] = w_cos_2;
        w_in[3] = w_sin_2;
    end

    // E0: sample accept; history shift, window count and weight capture on the first sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q    <= '0;
            win_cnt_q <= '0;
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
            for (int c = 0; c < 4; c++) shadow_q[c] <= '0;
        end else begin
            vld_p0_q  <= en;
            last_p0_q <= en & is_last;
            if (en) begin
                hist_q    <= {hist_q[TAPS-2:0], bit_in};
                win_cnt_q <= is_last ? '0 : win_cnt_q + 1'b1;
                if (is_first) begin
                    for (int c = 0; c < 4; c++) shadow_q[c] <= w_in[c];
                end
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_dot
        dsm_iq_correlator_dot8 u_dot (
            .clk   (clk),
            .reset (reset),
            .hist_i(hist_q),
            .w_i   (shadow_q[c]),
            .dot_o (dot_p2[c])
        );
    end

    // E1/E2: valid and last tags travel alongside the dot-product pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p0_q;
            last_p1_q <= last_p0_q;
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
        end
    end

    // Saturating next accumulator value per channel and any-channel clamp flag
    always_comb begin
        new_sat_d = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sum_d[c] = SUM_W'(acc_q[c]) + SUM_W'(dot_p2[c]);
            acc_d[c] = sat_val(sum_d[c]);
            if (sat_hit(sum_d[c])) new_sat_d = 1'b1;
        end
    end

    // E3: accumulate; on the last sample publish results and start a fresh window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                acc_q[c] <= '0;
                res_q[c] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (vld_p2_q) begin
                if (last_p2_q) begin
                    out_valid_q <= 1'b1;
                    overflow_q  <= sticky_q | new_sat_d;
                    sticky_q    <= 1'b0;
                    for (int c = 0; c < 4; c++) begin
                        res_q[c] <= acc_d[c];
                        acc_q[c] <= '0;
                    end
                end else begin
                    sticky_q <= sticky_q | new_sat_d;
                    for (int c = 0; c < 4; c++) acc_q[c] <= acc_d[c];
                end
            end
        end
    end

    assign i1        = res_q[0];
    assign q1        = res_q[1];
    assign i2        = res_q[2];
    assign q2        = res_q[3];
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dsm_iq_correlator.sv
// Directed bench for dsm_iq_correlator: default build, a 12-bit accumulator
// build for saturation, and a WIN_LEN=1 build, all sharing one stimulus.
module tb_dsm_iq_correlator;

    logic clk = 1'b0;
    logic reset, en, bit_in;
    logic [7:0][4:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;

    logic signed [15:0] i1_a, q1_a, i2_a, q2_a;
    logic               vld_a, ov_a;
    logic signed [11:0] i1_b, q1_b, i2_b, q2_b;
    logic               vld_b, ov_b;
    logic signed [15:0] i1_c, q1_c, i2_c, q2_c;
    logic               vld_c, ov_c;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int pa = 0, pb = 0, pc = 0, pa_cyc = 0;
    int a_i1 [16], a_q1 [16], a_i2 [16], a_q2 [16], a_ov [16];
    int b_i1 [16], b_q1 [16], b_ov [16];
    int c_i1 [128];

    dsm_iq_correlator #(.WIN_LEN(64), .ACC_W(16)) dut_a (
        .clk(clk), .reset(reset), .en(en), .bit_in(bit_in),
        .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2),
        .i1(i1_a), .q1(q1_a), .i2(i2_a), .q2(q2_a), .out_valid(vld_a), .overflow(ov_a)
    );

    dsm_iq_correlator #(.WIN_LEN(64), .ACC_W(12)) dut_b (
        .clk(clk), .reset(reset), .en(en), .bit_in(bit_in),
        .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2),
        .i1(i1_b), .q1(q1_b), .i2(i2_b), .q2(q2_b), .out_valid(vld_b), .overflow(ov_b)
    );

    dsm_iq_correlator #(.WIN_LEN(1), .ACC_W(16)) dut_c (
        .clk(clk), .reset(reset), .en(en), .bit_in(bit_in),
        .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2),
        .i1(i1_c), .q1(q1_c), .i2(i2_c), .q2(q2_c), .out_valid(vld_c), .overflow(ov_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every result pulse on the falling edge
    always @(negedge clk) begin
        if (vld_a) begin
            a_i1[pa % 16] = int'(i1_a);
            a_q1[pa % 16] = int'(q1_a);
            a_i2[pa % 16] = int'(i2_a);
            a_q2[pa % 16] = int'(q2_a);
            a_ov[pa % 16] = int'(ov_a);
            pa_cyc = cyc;
            pa = pa + 1;
        end
        if (vld_b) begin
            b_i1[pb % 16] = int'(i1_b);
            b_q1[pb % 16] = int'(q1_b);
            b_ov[pb % 16] = int'(ov_b);
            pb = pb + 1;
        end
        if (vld_c) begin
            c_i1[pc % 128] = int'(i1_c);
            pc = pc + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_w(input logic [4:0] c1, input logic [4:0] s1,
                         input logic [4:0] c2, input logic [4:0] s2);
        w_cos_1 = {8{c1}};
        w_sin_1 = {8{s1}};
        w_cos_2 = {8{c2}};
        w_sin_2 = {8{s2}};
    endtask

    task automatic do_reset();
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic b, input logic e);
        @(negedge clk);
        bit_in = b;
        en     = e;
        @(posedge clk);
        #1;
        if (e) acc_cyc = cyc;
    endtask

    task automatic run(input int n, input logic b);
        for (int i = 0; i < n; i++) send(b, 1'b1);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    task automatic wait_pulses(input string tag, input int target);
        int n;
        n = 0;
        while (pa < target && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, pa, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bbase, cbase;
        reset  = 1'b1;
        en     = 1'b0;
        bit_in = 1'b0;
        set_w(5'h00, 5'h00, 5'h00, 5'h00);
        repeat (2) @(negedge clk);
        chk("rst_i1", int'(i1_a), 0);
        chk("rst_vld", int'(vld_a), 0);
        chk("rst_ov", int'(ov_a), 0);
        reset = 1'b0;

        // Test 1: cos1 weights +1, steady ones -> sum of fill ramp plus 57*8
        set_w(5'h01, 5'h00, 5'h00, 5'h00);
        base  = pa;
        cbase = pc;
        run(64, 1'b1);
        wait_pulses("t1_pulse", base + 1);
        chk("t1_i1", a_i1[base % 16], 456);
        chk("t1_q1", a_q1[base % 16], 0);
        chk("t1_ov", a_ov[base % 16], 0);
        chk("t1_latency", pa_cyc - acc_cyc, 3);
        idle(5);
        chk("t1_once", pa, base + 1);
        chk("t1_hold_i1", int'(i1_a), 456);
        chk("c_first_i1", c_i1[cbase % 128], -6);
        chk("c_last_i1", c_i1[(cbase + 63) % 128], 8);
        chk("c_count", pc - cbase, 64);

        // Test 2: all sets -16, zero history -> +128 per sample
        do_reset();
        chk("t2_rst_i1", int'(i1_a), 0);
        chk("t2_rst_vld", int'(vld_a), 0);
        set_w(5'h10, 5'h10, 5'h10, 5'h10);
        base = pa;
        run(64, 1'b0);
        wait_pulses("t2_pulse", base + 1);
        chk("t2_i1", a_i1[base % 16], 8192);
        chk("t2_q1", a_q1[base % 16], 8192);
        chk("t2_i2", a_i2[base % 16], 8192);
        chk("t2_q2", a_q2[base % 16], 8192);
        chk("t2_ov", a_ov[base % 16], 0);

        // Test 3: weight change mid-window only takes effect next window
        do_reset();
        set_w(5'h01, 5'h00, 5'h00, 5'h00);
        base = pa;
        run(10, 1'b1);
        w_cos_1 = {8{5'h02}};
        run(54, 1'b1);
        run(64, 1'b1);
        wait_pulses("t3_pulse", base + 2);
        chk("t3_w1_i1", a_i1[base % 16], 456);
        chk("t3_w2_i1", a_i1[(base + 1) % 16], 1024);

        // Test 4: en alternating, idle slots carry bit_in=0 that must be ignored
        do_reset();
        set_w(5'h01, 5'h00, 5'h00, 5'h00);
        base = pa;
        for (int i = 0; i < 64; i++) begin
            send(1'b1, 1'b1);
            send(1'b0, 1'b0);
        end
        wait_pulses("t4_pulse", base + 1);
        chk("t4_i1", a_i1[base % 16], 456);
        chk("t4_latency", pa_cyc - acc_cyc, 3);

        // Test 5: 12-bit accumulator clamps; overflow recomputed per window
        do_reset();
        set_w(5'h0F, 5'h0F, 5'h0F, 5'h0F);
        base  = pa;
        bbase = pb;
        run(10, 1'b1);
        set_w(5'h01, 5'h01, 5'h01, 5'h01);
        run(54, 1'b1);
        run(10, 1'b1);
        set_w(5'h0F, 5'h0F, 5'h0F, 5'h0F);
        run(54, 1'b1);
        run(64, 1'b0);
        wait_pulses("t5_pulse", base + 3);
        chk("t5_b_count", pb - bbase, 3);
        chk("t5_wA_i1", b_i1[bbase % 16], 2047);
        chk("t5_wA_q1", b_q1[bbase % 16], 2047);
        chk("t5_wA_ov", b_ov[bbase % 16], 1);
        chk("t5_wB_i1", b_i1[(bbase + 1) % 16], 512);
        chk("t5_wB_ov", b_ov[(bbase + 1) % 16], 0);
        chk("t5_wC_i1", b_i1[(bbase + 2) % 16], -2048);
        chk("t5_wC_ov", b_ov[(bbase + 2) % 16], 1);
        chk("t5_a_wA_i1", a_i1[base % 16], 6840);
        chk("t5_a_wC_i1", a_i1[(base + 2) % 16], -6840);
        chk("t5_a_wC_ov", a_ov[(base + 2) % 16], 0);

        // Test 6: reset mid-window discards the partial window
        do_reset();
        set_w(5'h01, 5'h00, 5'h00, 5'h00);
        base = pa;
        run(30, 1'b1);
        do_reset();
        run(64, 1'b1);
        wait_pulses("t6_pulse", base + 1);
        idle(5);
        chk("t6_once", pa, base + 1);
        chk("t6_i1", a_i1[base % 16], 456);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dsm_iq_correlator.md
Name: dsm_iq_correlator

Overview:
Consumes the four 8-tap weight vectors held by the SPI register file (w_cos_1, w_sin_1, w_cos_2, w_sin_2) and correlates them against the 1-bit delta-sigma bitstream. Produces two I/Q pairs as windowed sums. Per accepted sample, each weight set forms an 8-tap signed dot product against the bitstream history. These are accumulated over WIN_LEN samples and emitted with a one-cycle valid pulse. Sits directly downstream of the SPI register block, in the modulator clock domain.

Parameters:
WIN_LEN, 64, accepted samples per integration window (>=1)
ACC_W, 16, accumulator/output width, signed two's complement
W_W, 5, weight width, signed two's complement (fixed by SPI block)
TAPS, 8, taps per weight vector (fixed by SPI block)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
en  in  1  sample strobe; bit_in accepted on rising clk when 1
bit_in  in  1  delta-sigma bitstream sample
w_cos_1  in  [7:0][4:0]  weight set cos1, tap k = w_cos_1[k]
w_sin_1  in  [7:0][4:0]  weight set sin1
w_cos_2  in  [7:0][4:0]  weight set cos2
w_sin_2  in  [7:0][4:0]  weight set sin2
i1, q1, i2, q2  out  ACC_W  signed window results (cos1, sin1, cos2, sin2)
out_valid  out  1  one-cycle pulse, results valid
overflow  out  1  saturation occurred in the reported window; valid with out_valid

Behaviour:
- Reset: clk single clock domain; reset asynchronous, active-high. Clears history, shadow weights, all pipeline registers, the window counter, accumulators, sticky overflow, and outputs. i1/q1/i2/q2=0, out_valid=0, overflow=0.
- History: hist[7:0]. On en=1: hist <= {hist[6:0], bit_in}. Tap k uses hist[k]. hist is held when en=0. It is not cleared between windows, only by reset.
- Term rule: hist[k]=1 -> +w[k]; hist[k]=0 -> -w[k]. Sign-extend to 9 bits before negating (-(-16)=+16 is legal).
- Dot product: sum of 8 terms, 9-bit signed, range -128..+128.
- Weight shadowing: on the first accepted sample of a window (win_cnt==0 and en), all four input vectors are captured into shadow registers. That first sample already uses the captured values. Input changes mid-window have no effect until the next window.
- Window counter: win_cnt runs 0..WIN_LEN-1 and advances on en. The sample with win_cnt==WIN_LEN-1 is tagged last, and the counter then wraps to 0. With WIN_LEN=1, every sample is both first and last.
- Pipeline, with valid and last tags carried alongside the data:
  - E0: sample accept.
  - E1: per-tap terms registered.
  - E2: 4 dot products registered.
  - E3: accumulate.
  - Bubbles from en=0 propagate; there is no stall or backpressure.
- Accumulate at E3 when the tag is valid: acc <= sat(acc + dot).
  - If the tag is also last: outputs <= sat(acc + dot), out_valid=1 for exactly one cycle, overflow <= sticky|new_sat. Accumulators and sticky then clear to 0 for the next window.
  - Latency: out_valid rises 3 clocks after the edge that accepts the last sample.
- Saturation: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] independently per channel. The sticky flag is set if any channel clamps. With default parameters saturation is unreachable (64*128 < 32767).
- Outputs hold their last values between out_valid pulses.
- Reset mid-window: the partial window is discarded, no out_valid is produced, and the next window starts at win_cnt=0.

Decomposition:
- Shared package holds:
  - W_W and TAPS constants.
  - typedef weight_vec_t = logic [TAPS-1:0][W_W-1:0] signed lanes.
  - typedef dot_t = 9-bit signed.
  - The SPI address constants, shared with the SPI register block.
- Sub-module dsm_dot8: 8 signed terms plus adder tree, registered at E1/E2. Instanced 4x, once per weight set.
- Window counter, shadowing, accumulate/saturate and output logic stay in the top module.

Test Plan:
- Reset, then w_cos_1 all taps 5'h01, bit_in=1 continuously, en=1, WIN_LEN=64.
  -> dot = 2k-8 for k=1..7, then 8 -> i1=456, out_valid 3 clks after the 64th accept, overflow=0.
- All four sets at 5'h10 (-16), bit_in=0 continuously.
  -> each dot=+128 after fill -> i1=q1=i2=q2=8192.
- Test 1 setup, but w_cos_1 changed to 5'h02 at sample 10.
  -> window 1 i1=456 unchanged; window 2 i1 = 64*16 = 1024.
- Test 1 with en toggling 1,0,1,0.
  -> identical i1=456; out_valid after the 64th accepted sample (~128 clks).
- ACC_W=12, all weights 5'h0F, bit_in=1.
  -> sum 7680-fill effect clamps -> i1=2047, overflow=1 with out_valid; next window overflow recomputed.
- Assert reset after 30 samples, release, then run 64 samples.
  -> no pulse for the aborted window; exactly one pulse after 64 post-reset samples with test-1 values.
